// File: rtl/mempool_tile_req_distributor.sv
// mempool_tile_req_distributor
// Dispatches remote requests from NumInp tile request ports to NumOut bank ports.
// Each input has a small FIFO. Each bank has a round-robin arbiter. A lock holds
// the granted input on a stalled bank until its handshake completes.
// Optional starvation guard is built when MEMPOOL_REQ_DIST_STARVE_EN is defined.
//
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   data_i/bank_i  per-input payload and target bank index
//   valid_i        per-input request valid
//   ready_o        per-input FIFO-not-full; forced low while in reset
//   data_o/valid_o per-bank request payload and valid
//   ready_i        per-bank accept
module mempool_tile_req_distributor #(
  parameter int unsigned  NumInp      = 3,
  parameter int unsigned  NumOut      = 16,
  parameter int unsigned  FifoDepth   = 2,
  parameter int unsigned  StarveLimit = 8,
  parameter type          payload_t   = logic,
  localparam int unsigned BankW       = (NumOut > 1) ? $clog2(NumOut) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  payload_t [NumInp-1:0]        data_i,
  input  logic [NumInp-1:0][BankW-1:0] bank_i,
  input  logic [NumInp-1:0]            valid_i,
  output logic [NumInp-1:0]            ready_o,
  output payload_t [NumOut-1:0]        data_o,
  output logic [NumOut-1:0]            valid_o,
  input  logic [NumOut-1:0]            ready_i
);

  localparam int unsigned IdxW = (NumInp > 1) ? $clog2(NumInp) : 1;
  localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CntW = $clog2(FifoDepth + 1);

  typedef struct packed {
    payload_t         data;
    logic [BankW-1:0] bank;
  } entry_t;

  entry_t            mem_q    [NumInp][FifoDepth];
  logic [PtrW-1:0]   wr_ptr_q [NumInp];
  logic [PtrW-1:0]   wr_ptr_d [NumInp];
  logic [PtrW-1:0]   rd_ptr_q [NumInp];
  logic [PtrW-1:0]   rd_ptr_d [NumInp];
  logic [CntW-1:0]   cnt_q    [NumInp];
  logic [CntW-1:0]   cnt_d    [NumInp];
  entry_t            head     [NumInp];
  logic [NumInp-1:0] not_empty, push, pop;

  logic [IdxW-1:0]   rr_q       [NumOut];
  logic [IdxW-1:0]   rr_d       [NumOut];
  logic [IdxW-1:0]   lock_idx_q [NumOut];
  logic [IdxW-1:0]   lock_idx_d [NumOut];
  logic [NumOut-1:0] lock_vld_q, lock_vld_d;
  logic [IdxW-1:0]   win        [NumOut];
  logic [NumInp-1:0] cand       [NumOut];
  logic [NumOut-1:0] hs;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FifoDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // FIFO status and push qualification; ready_o depends on stored state only
  always_comb begin
    for (int i = 0; i < NumInp; i++) begin
      head[i]      = mem_q[i][rd_ptr_q[i]];
      not_empty[i] = (cnt_q[i] != '0);
      ready_o[i]   = ~rst_i & (cnt_q[i] != CntW'(FifoDepth));
      push[i]      = valid_i[i] & ready_o[i];
    end
  end

`ifdef MEMPOOL_REQ_DIST_STARVE_EN
  localparam int unsigned WaitW = $clog2(StarveLimit + 1);

  logic [WaitW-1:0]  wait_q [NumInp];
  logic [WaitW-1:0]  wait_d [NumInp];
  logic [NumInp-1:0] starved;

  // Wait counters: count every cycle a queued head is not popped, saturating
  always_comb begin
    for (int i = 0; i < NumInp; i++) begin
      starved[i] = (wait_q[i] >= WaitW'(StarveLimit));
      wait_d[i]  = wait_q[i];
      if (pop[i]) begin
        wait_d[i] = '0;
      end else if (not_empty[i] && !starved[i]) begin
        wait_d[i] = wait_q[i] + WaitW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumInp; i++) wait_q[i] <= '0;
    end else begin
      for (int i = 0; i < NumInp; i++) wait_q[i] <= wait_d[i];
    end
  end
`endif

  // Per-bank arbitration: lock owner, then (optionally) starved input, then round robin
  always_comb begin
    logic        found;
    int unsigned idx;
    valid_o = '0;
    data_o  = '0;
    hs      = '0;
    for (int b = 0; b < NumOut; b++) begin
      win[b] = rr_q[b];
      found  = 1'b0;
      for (int i = 0; i < NumInp; i++) begin
        cand[b][i] = not_empty[i] & (head[i].bank == BankW'(b));
      end
      if (lock_vld_q[b]) begin
        win[b] = lock_idx_q[b];
        found  = 1'b1;
      end
`ifdef MEMPOOL_REQ_DIST_STARVE_EN
      for (int i = 0; i < NumInp; i++) begin
        if (!found && cand[b][i] && starved[i]) begin
          win[b] = IdxW'(i);
          found  = 1'b1;
        end
      end
`endif
      for (int k = 0; k < NumInp; k++) begin
        idx = int'(rr_q[b]) + k;
        if (idx >= NumInp) idx = idx - NumInp;
        if (!found && cand[b][idx]) begin
          win[b] = IdxW'(idx);
          found  = 1'b1;
        end
      end
      valid_o[b] = |cand[b];
      if (valid_o[b]) data_o[b] = head[win[b]].data;
      hs[b] = valid_o[b] & ready_i[b];
    end
  end

  // A head targets a single bank, so each input sees at most one pop
  always_comb begin
    pop = '0;
    for (int b = 0; b < NumOut; b++) begin
      if (hs[b]) pop[win[b]] = 1'b1;
    end
  end

  // Round-robin pointer advances past the winner on handshake; lock holds a stalled grant
  always_comb begin
    lock_vld_d = lock_vld_q;
    for (int b = 0; b < NumOut; b++) begin
      rr_d[b]       = rr_q[b];
      lock_idx_d[b] = lock_idx_q[b];
      if (hs[b]) begin
        rr_d[b]       = (win[b] == IdxW'(NumInp - 1)) ? '0 : win[b] + IdxW'(1);
        lock_vld_d[b] = 1'b0;
      end else if (valid_o[b]) begin
        lock_vld_d[b] = 1'b1;
        lock_idx_d[b] = win[b];
      end
    end
  end

  // FIFO pointer and occupancy next state
  always_comb begin
    for (int i = 0; i < NumInp; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      cnt_d[i]    = cnt_q[i];
      if (push[i]) wr_ptr_d[i] = ptr_inc(wr_ptr_q[i]);
      if (pop[i])  rd_ptr_d[i] = ptr_inc(rd_ptr_q[i]);
      if (push[i] && !pop[i]) begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end else if (!push[i] && pop[i]) begin
        cnt_d[i] = cnt_q[i] - CntW'(1);
      end
    end
  end

  // Control state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumInp; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      for (int b = 0; b < NumOut; b++) begin
        rr_q[b]       <= '0;
        lock_idx_q[b] <= '0;
      end
      lock_vld_q <= '0;
    end else begin
      for (int i = 0; i < NumInp; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      for (int b = 0; b < NumOut; b++) begin
        rr_q[b]       <= rr_d[b];
        lock_idx_q[b] <= lock_idx_d[b];
      end
      lock_vld_q <= lock_vld_d;
    end
  end

  // FIFO storage: payload and bank index stored together
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NumInp; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= '{data: data_i[i], bank: bank_i[i]};
    end
  end

  if (FifoDepth < 1 || StarveLimit < 1) begin : g_bad_param
    $error("FifoDepth and StarveLimit must be at least 1");
  end

`ifndef SYNTHESIS
  // Bank indices beyond NumOut are only representable for non power-of-2 NumOut
  if (NumOut != (2 ** BankW)) begin : g_bank_chk
    for (genvar i = 0; i < NumInp; i++) begin : g_inp
      bank_in_range : assert property (@(posedge clk_i) disable iff (rst_i)
        valid_i[i] |-> (32'(bank_i[i]) < NumOut));
    end
  end
`endif

endmodule

// File: tb/tb_mempool_tile_req_distributor.sv
module tb_mempool_tile_req_distributor;

  localparam int NI = 3;
  localparam int NO = 16;
  localparam int FD = 2;
  localparam int SL = 2;

  typedef logic [7:0] pl_t;

  logic                  clk = 1'b0;
  logic                  rst_i;
  pl_t  [NI-1:0]         data_i;
  logic [NI-1:0][3:0]    bank_i;
  logic [NI-1:0]         valid_i;
  logic [NI-1:0]         ready_o;
  pl_t  [NO-1:0]         data_o;
  logic [NO-1:0]         valid_o;
  logic [NO-1:0]         ready_i;

  mempool_tile_req_distributor #(
    .NumInp(NI), .NumOut(NO), .FifoDepth(FD), .StarveLimit(SL), .payload_t(pl_t)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .data_i(data_i), .bank_i(bank_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i)
  );

  always #5 clk = ~clk;

  // Reference model: per-input queues (index 0 = oldest), per-bank pointer and lock owner
  pl_t m_dat  [NI][FD];
  int  m_bnk  [NI][FD];
  int  m_cnt  [NI];
  int  m_wait [NI];
  int  m_rr   [NO];
  int  m_lock [NO];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic void mreset();
    for (int i = 0; i < NI; i++) begin m_cnt[i] = 0; m_wait[i] = 0; end
    for (int b = 0; b < NO; b++) begin m_rr[b] = 0; m_lock[b] = -1; end
  endfunction

  function automatic bool_head_at(int i, int b);
    return (m_cnt[i] > 0) && (m_bnk[i][0] == b);
  endfunction

  // Granted input for bank b, or -1 when no head targets it
  function automatic int mwin(int b);
    if (m_lock[b] >= 0) return m_lock[b];
`ifdef MEMPOOL_REQ_DIST_STARVE_EN
    for (int i = 0; i < NI; i++) begin
      if (bool_head_at(i, b) && m_wait[i] >= SL) return i;
    end
`endif
    for (int k = 0; k < NI; k++) begin
      if (bool_head_at((m_rr[b] + k) % NI, b)) return (m_rr[b] + k) % NI;
    end
    return -1;
  endfunction

  function automatic void mpop(int i);
    for (int j = 0; j < FD - 1; j++) begin
      m_dat[i][j] = m_dat[i][j+1];
      m_bnk[i][j] = m_bnk[i][j+1];
    end
    m_cnt[i]--;
  endfunction

  // Drive one cycle of inputs, compare outputs against the model, advance the model
  task automatic step(input logic [NI-1:0] v, input logic [NI-1:0][3:0] bk,
                      input pl_t [NI-1:0] dt, input logic [NO-1:0] rdy);
    int            w [NO];
    logic [NO-1:0] ev;
    pl_t  [NO-1:0] ed, gd;
    logic [NI-1:0] er, acc, popped, busy;
    valid_i = v; bank_i = bk; data_i = dt; ready_i = rdy;
    #1;
    ev = '0; ed = '0; gd = '0;
    for (int b = 0; b < NO; b++) begin
      w[b] = mwin(b);
      if (w[b] >= 0) begin ev[b] = 1'b1; ed[b] = m_dat[w[b]][0]; end
      if (valid_o[b]) gd[b] = data_o[b];
    end
    for (int i = 0; i < NI; i++) begin
      er[i]   = (m_cnt[i] < FD);
      busy[i] = (m_cnt[i] > 0);
    end
    check("ready_o", 128'(ready_o), 128'(er));
    check("valid_o", 128'(valid_o), 128'(ev));
    check("data_o",  128'(gd),      128'(ed));
    acc    = v & er;
    popped = '0;
    for (int b = 0; b < NO; b++) begin
      if (ev[b]) begin
        if (rdy[b]) begin
          mpop(w[b]);
          popped[w[b]] = 1'b1;
          m_rr[b]      = (w[b] + 1) % NI;
          m_lock[b]    = -1;
        end else begin
          m_lock[b] = w[b];
        end
      end
    end
    for (int i = 0; i < NI; i++) begin
      if (popped[i])     m_wait[i] = 0;
      else if (busy[i])  m_wait[i] = (m_wait[i] < SL) ? m_wait[i] + 1 : SL;
      if (acc[i]) begin
        m_dat[i][m_cnt[i]] = dt[i];
        m_bnk[i][m_cnt[i]] = int'(bk[i]);
        m_cnt[i]++;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, '0, '0, '1);
  endtask

  localparam logic [NO-1:0] BP7 = 16'hFF7F;

  initial begin
    rst_i = 1'b1; valid_i = '0; bank_i = '0; data_i = '0; ready_i = '1;
    mreset();
    repeat (2) @(negedge clk);
    check("rst_ready", 128'(ready_o), 128'(0));
    check("rst_valid", 128'(valid_o), 128'(0));
    check("rst_data",  128'(data_o),  128'(0));
    rst_i = 1'b0;
    #1;
    check("post_rst_ready", 128'(ready_o), 128'(3'b111));

    // Single request: input 0 -> bank 5
    step(3'b001, {4'd0, 4'd0, 4'd5}, {8'h00, 8'h00, 8'hA1}, '1);
    check("single_valid", 128'(valid_o), 128'(16'h0020));
    check("single_data",  128'(data_o[5]), 128'(8'hA1));
    idle(1);
    check("single_once", 128'(valid_o), 128'(0));

    // Three inputs collide on bank 3: grants 0, 1, 2
    step(3'b111, {4'd3, 4'd3, 4'd3}, {8'h12, 8'h11, 8'h10}, '1);
    check("conf_g0", 128'(data_o[3]), 128'(8'h10));
    idle(1);
    check("conf_g1", 128'(data_o[3]), 128'(8'h11));
    idle(1);
    check("conf_g2", 128'(data_o[3]), 128'(8'h12));
    idle(1);
    check("conf_done", 128'(valid_o), 128'(0));
    // rr[3] back at 0: a fresh collision starts again with input 0
    step(3'b111, {4'd3, 4'd3, 4'd3}, {8'h22, 8'h21, 8'h20}, '1);
    check("conf_rr0", 128'(data_o[3]), 128'(8'h20));
    idle(3);

    // Backpressure on bank 7 for four cycles
    step(3'b010, {4'd0, 4'd7, 4'd0}, {8'h00, 8'h71, 8'h00}, BP7);
    step(3'b010, {4'd0, 4'd7, 4'd0}, {8'h00, 8'h72, 8'h00}, BP7);
    check("bp_full", 128'(ready_o[1]), 128'(1'b0));
    check("bp_head", 128'(data_o[7]), 128'(8'h71));
    step(3'b010, {4'd0, 4'd7, 4'd0}, {8'h00, 8'h73, 8'h00}, BP7);
    step(3'b010, {4'd0, 4'd7, 4'd0}, {8'h00, 8'h73, 8'h00}, BP7);
    check("bp_stable", 128'(data_o[7]), 128'(8'h71));
    step(3'b010, {4'd0, 4'd7, 4'd0}, {8'h00, 8'h73, 8'h00}, '1);
    step(3'b010, {4'd0, 4'd7, 4'd0}, {8'h00, 8'h73, 8'h00}, '1);
    idle(3);

    // Parallel dispatch to banks 0, 1, 2
    step(3'b111, {4'd2, 4'd1, 4'd0}, {8'hC2, 8'hC1, 8'hC0}, '1);
    check("par_valid", 128'(valid_o), 128'(16'h0007));
    idle(1);

    // Reset with two entries in every FIFO
    step(3'b111, {4'd10, 4'd9, 4'd8}, {8'hD2, 8'hD1, 8'hD0}, '0);
    step(3'b111, {4'd10, 4'd9, 4'd8}, {8'hE2, 8'hE1, 8'hE0}, '0);
    valid_i = '0;
    rst_i   = 1'b1;
    #1;
    check("mid_rst_valid", 128'(valid_o), 128'(0));
    check("mid_rst_ready", 128'(ready_o), 128'(0));
    mreset();
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    check("rel_ready", 128'(ready_o), 128'(3'b111));
    check("rel_valid", 128'(valid_o), 128'(0));
    // rr[7] was 2 before reset; input 0 must now win first
    step(3'b101, {4'd7, 4'd0, 4'd7}, {8'hB2, 8'h00, 8'hB0}, '1);
    check("rel_rr", 128'(data_o[7]), 128'(8'hB0));
    idle(3);

`ifdef MEMPOOL_REQ_DIST_STARVE_EN
    // Inputs 0 and 2 hammer bank 4 while input 1 waits behind a lock held by input 0
    step(3'b101, {4'd4, 4'd0, 4'd4}, {8'h40, 8'h00, 8'h42}, 16'hFFEF);
    step(3'b010, {4'd0, 4'd4, 4'd0}, {8'h00, 8'h41, 8'h00}, 16'hFFEF);
    step(3'b000, '0, '0, 16'hFFEF);
    step(3'b000, '0, '0, 16'hFFEF);
    for (int k = 0; k < 8; k++) step(3'b101, {4'd4, 4'd0, 4'd4}, {8'h50, 8'h00, 8'h52}, '1);
    idle(6);
`endif

    // Randomized traffic: narrow bank range first for heavy conflict, then full range
    for (int c = 0; c < 1500; c++) begin
      logic [NI-1:0]      v;
      logic [NI-1:0][3:0] bk;
      pl_t  [NI-1:0]      dt;
      logic [NO-1:0]      r;
      for (int i = 0; i < NI; i++) begin
        v[i]  = ($urandom_range(0, 3) != 0);
        bk[i] = (c < 800) ? 4'($urandom_range(0, 3)) : 4'($urandom);
        dt[i] = 8'($urandom);
      end
      r = 16'($urandom) | 16'($urandom);
      step(v, bk, dt, r);
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
